// File: rtl/ysyx_210238_ram_axi_bridge_pkg.sv
// Shared AXI constants, bridge FSM encodings and small decode helpers.
package ysyx_210238_ram_axi_bridge_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AWW  = 3'd3,
        ST_B    = 3'd4,
        ST_DONE = 3'd5
    } bridge_state_e;

    // RAM-side size codes above D are treated as D.
    function automatic logic [1:0] clamp_size(input logic [2:0] size);
        return (size > 3'd3) ? 2'd3 : size[1:0];
    endfunction

    // Byte-enable pattern for an LSB-aligned access of the given size.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            2'd0:    mask = 8'h01;
            2'd1:    mask = 8'h03;
            2'd2:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ysyx_210238_axi_lane_align.sv
// Byte-lane alignment between the LSB-aligned RAM port and the 64-bit AXI data lanes.
module ysyx_210238_axi_lane_align
    import ysyx_210238_ram_axi_bridge_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [2:0]  i_offset,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_rdata,
    output logic [7:0]  o_strb,
    output logic [63:0] o_wdata,
    output logic [63:0] o_rdata
);

    logic [5:0] w_shamt;

    // Shift strobes/write data up to their lanes and read data down to bit 0;
    // bits pushed past the top of the bus are dropped.
    always_comb begin
        w_shamt = {i_offset, 3'b000};
        o_strb  = size_mask(i_size) << i_offset;
        o_wdata = i_wdata << w_shamt;
        o_rdata = i_rdata >> w_shamt;
    end

endmodule

// File: rtl/ysyx_210238_ram_axi_bridge.sv
// RAM request port to single-beat AXI4 master bridge, one transaction in flight.
//
// state   | meaning
// IDLE    | waiting for i_ram_valid; request fields captured on accept
// AR      | read address presented until arready
// R       | rready high, waiting for the single read beat
// AWW     | write address and data presented, each drops after its own handshake
// B       | bready high, waiting for the write response
// DONE    | one-cycle completion pulse back to the RAM side
module ysyx_210238_ram_axi_bridge
    import ysyx_210238_ram_axi_bridge_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_ID_W   = 4,
    parameter int AXI_ID     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [63:0]           i_ram_addr,
    input  logic                  i_ram_wen,
    input  logic                  i_ram_valid,
    input  logic [63:0]           i_ram_wdata,
    input  logic [2:0]            i_ram_size,
    output logic                  o_ram_ready,
    output logic [63:0]           o_ram_rdata,
    output logic                  o_bus_err,
    output logic                  o_axi_aw_valid,
    output logic [AXI_ADDR_W-1:0] o_axi_aw_addr,
    output logic [AXI_ID_W-1:0]   o_axi_aw_id,
    output logic [7:0]            o_axi_aw_len,
    output logic [2:0]            o_axi_aw_size,
    output logic [1:0]            o_axi_aw_burst,
    input  logic                  i_axi_aw_ready,
    output logic                  o_axi_w_valid,
    output logic [63:0]           o_axi_w_data,
    output logic [7:0]            o_axi_w_strb,
    output logic                  o_axi_w_last,
    input  logic                  i_axi_w_ready,
    input  logic                  i_axi_b_valid,
    input  logic [AXI_ID_W-1:0]   i_axi_b_id,
    input  logic [1:0]            i_axi_b_resp,
    output logic                  o_axi_b_ready,
    output logic                  o_axi_ar_valid,
    output logic [AXI_ADDR_W-1:0] o_axi_ar_addr,
    output logic [AXI_ID_W-1:0]   o_axi_ar_id,
    output logic [7:0]            o_axi_ar_len,
    output logic [2:0]            o_axi_ar_size,
    output logic [1:0]            o_axi_ar_burst,
    input  logic                  i_axi_ar_ready,
    input  logic                  i_axi_r_valid,
    input  logic [AXI_ID_W-1:0]   i_axi_r_id,
    input  logic [1:0]            i_axi_r_resp,
    input  logic [63:0]           i_axi_r_data,
    input  logic                  i_axi_r_last,
    output logic                  o_axi_r_ready
);

    bridge_state_e         r_state;
    bridge_state_e         w_state_nxt;
    logic [AXI_ADDR_W-1:0] r_addr;
    logic [1:0]            r_size;
    logic [63:0]           r_wdata;
    logic [7:0]            r_strb;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  r_err;
    logic [63:0]           r_ram_rdata;

    logic [2:0]            w_offset;
    logic [7:0]            w_strb_lane;
    logic [63:0]           w_wdata_lane;
    logic [63:0]           w_rdata_lane;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_unused_inputs;

    // IDTs and RLAST carry no information with a single outstanding beat.
    assign w_unused_inputs = ^{i_axi_b_id, i_axi_r_id, i_axi_r_last, i_ram_addr[63:AXI_ADDR_W]};

    // The incoming address sets the write lanes on accept; the held address aligns read data.
    assign w_offset = (r_state == ST_IDLE) ? i_ram_addr[2:0] : r_addr[2:0];

    ysyx_210238_axi_lane_align u_lane_align (
        .i_size  (clamp_size(i_ram_size)),
        .i_offset(w_offset),
        .i_wdata (i_ram_wdata),
        .i_rdata (i_axi_r_data),
        .o_strb  (w_strb_lane),
        .o_wdata (w_wdata_lane),
        .o_rdata (w_rdata_lane)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs, decoded from registered state and flags only.
    always_comb begin
        w_state_nxt    = r_state;
        o_axi_ar_valid = 1'b0;
        o_axi_r_ready  = 1'b0;
        o_axi_aw_valid = 1'b0;
        o_axi_w_valid  = 1'b0;
        o_axi_b_ready  = 1'b0;
        o_ram_ready    = 1'b0;
        o_bus_err      = 1'b0;
        w_aw_hs        = 1'b0;
        w_w_hs         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_ram_valid) w_state_nxt = i_ram_wen ? ST_AWW : ST_AR;
            end
            ST_AR: begin
                o_axi_ar_valid = 1'b1;
                if (i_axi_ar_ready) w_state_nxt = ST_R;
            end
            ST_R: begin
                o_axi_r_ready = 1'b1;
                if (i_axi_r_valid) w_state_nxt = ST_DONE;
            end
            ST_AWW: begin
                o_axi_aw_valid = !r_aw_done;
                o_axi_w_valid  = !r_w_done;
                w_aw_hs        = o_axi_aw_valid & i_axi_aw_ready;
                w_w_hs         = o_axi_w_valid & i_axi_w_ready;
                if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) w_state_nxt = ST_B;
            end
            ST_B: begin
                o_axi_b_ready = 1'b1;
                if (i_axi_b_valid) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_ram_ready = 1'b1;
                o_bus_err   = r_err;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request holding registers, sticky write-channel flags, response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_size      <= '0;
            r_wdata     <= '0;
            r_strb      <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_err       <= 1'b0;
            r_ram_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_ram_valid) begin
                        r_addr    <= i_ram_addr[AXI_ADDR_W-1:0];
                        r_size    <= clamp_size(i_ram_size);
                        r_wdata   <= w_wdata_lane;
                        r_strb    <= w_strb_lane;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_err     <= 1'b0;
                    end
                end
                ST_R: begin
                    if (i_axi_r_valid) begin
                        r_ram_rdata <= w_rdata_lane;
                        r_err       <= (i_axi_r_resp != AXI_RESP_OKAY);
                    end
                end
                ST_AWW: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                end
                ST_B: begin
                    if (i_axi_b_valid) r_err <= (i_axi_b_resp != AXI_RESP_OKAY);
                end
                default: ;
            endcase
        end
    end

    assign o_ram_rdata    = r_ram_rdata;
    assign o_axi_aw_addr  = r_addr;
    assign o_axi_ar_addr  = r_addr;
    assign o_axi_aw_id    = AXI_ID_W'(AXI_ID);
    assign o_axi_ar_id    = AXI_ID_W'(AXI_ID);
    assign o_axi_aw_len   = 8'd0;
    assign o_axi_ar_len   = 8'd0;
    assign o_axi_aw_size  = {1'b0, r_size};
    assign o_axi_ar_size  = {1'b0, r_size};
    assign o_axi_aw_burst = AXI_BURST_INCR;
    assign o_axi_ar_burst = AXI_BURST_INCR;
    assign o_axi_w_data   = r_wdata;
    assign o_axi_w_strb   = r_strb;
    assign o_axi_w_last   = 1'b1;

endmodule

// File: tb/tb_ysyx_210238_ram_axi_bridge.sv
// Table-driven bench for the RAM-to-AXI bridge with a delay-programmable AXI slave.
module tb_ysyx_210238_ram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] i_ram_addr;
    logic        i_ram_wen;
    logic        i_ram_valid;
    logic [63:0] i_ram_wdata;
    logic [2:0]  i_ram_size;
    logic        o_ram_ready;
    logic [63:0] o_ram_rdata;
    logic        o_bus_err;
    logic        o_axi_aw_valid;
    logic [31:0] o_axi_aw_addr;
    logic [3:0]  o_axi_aw_id;
    logic [7:0]  o_axi_aw_len;
    logic [2:0]  o_axi_aw_size;
    logic [1:0]  o_axi_aw_burst;
    logic        i_axi_aw_ready;
    logic        o_axi_w_valid;
    logic [63:0] o_axi_w_data;
    logic [7:0]  o_axi_w_strb;
    logic        o_axi_w_last;
    logic        i_axi_w_ready;
    logic        i_axi_b_valid;
    logic [3:0]  i_axi_b_id;
    logic [1:0]  i_axi_b_resp;
    logic        o_axi_b_ready;
    logic        o_axi_ar_valid;
    logic [31:0] o_axi_ar_addr;
    logic [3:0]  o_axi_ar_id;
    logic [7:0]  o_axi_ar_len;
    logic [2:0]  o_axi_ar_size;
    logic [1:0]  o_axi_ar_burst;
    logic        i_axi_ar_ready;
    logic        i_axi_r_valid;
    logic [3:0]  i_axi_r_id;
    logic [1:0]  i_axi_r_resp;
    logic [63:0] i_axi_r_data;
    logic        i_axi_r_last;
    logic        o_axi_r_ready;

    ysyx_210238_ram_axi_bridge dut (
        .clk(clk), .rst(rst),
        .i_ram_addr(i_ram_addr), .i_ram_wen(i_ram_wen), .i_ram_valid(i_ram_valid),
        .i_ram_wdata(i_ram_wdata), .i_ram_size(i_ram_size),
        .o_ram_ready(o_ram_ready), .o_ram_rdata(o_ram_rdata), .o_bus_err(o_bus_err),
        .o_axi_aw_valid(o_axi_aw_valid), .o_axi_aw_addr(o_axi_aw_addr), .o_axi_aw_id(o_axi_aw_id),
        .o_axi_aw_len(o_axi_aw_len), .o_axi_aw_size(o_axi_aw_size), .o_axi_aw_burst(o_axi_aw_burst),
        .i_axi_aw_ready(i_axi_aw_ready),
        .o_axi_w_valid(o_axi_w_valid), .o_axi_w_data(o_axi_w_data), .o_axi_w_strb(o_axi_w_strb),
        .o_axi_w_last(o_axi_w_last), .i_axi_w_ready(i_axi_w_ready),
        .i_axi_b_valid(i_axi_b_valid), .i_axi_b_id(i_axi_b_id), .i_axi_b_resp(i_axi_b_resp),
        .o_axi_b_ready(o_axi_b_ready),
        .o_axi_ar_valid(o_axi_ar_valid), .o_axi_ar_addr(o_axi_ar_addr), .o_axi_ar_id(o_axi_ar_id),
        .o_axi_ar_len(o_axi_ar_len), .o_axi_ar_size(o_axi_ar_size), .o_axi_ar_burst(o_axi_ar_burst),
        .i_axi_ar_ready(i_axi_ar_ready),
        .i_axi_r_valid(i_axi_r_valid), .i_axi_r_id(i_axi_r_id), .i_axi_r_resp(i_axi_r_resp),
        .i_axi_r_data(i_axi_r_data), .i_axi_r_last(i_axi_r_last), .o_axi_r_ready(o_axi_r_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [63:0] slv_rdata;
        logic [1:0]  resp;
        int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
        logic [2:0]  exp_axsize;
        logic [7:0]  exp_strb;
        logic [63:0] exp_wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
        bit          chain;
    } vec_t;

    typedef struct {
        logic        wen;
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } sb_t;

    localparam int NVEC = 12;
    vec_t        vec[NVEC];
    sb_t         sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          ar_hs_total = 0;
    logic [63:0] last_rdata = '0;
    logic        prev_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wen, input logic [63:0] addr, input logic [2:0] size,
                                input logic [63:0] wdata, input logic [63:0] srd, input logic [1:0] resp,
                                input int ard, input int rd, input int awd, input int wd, input int bd,
                                input logic [2:0] exsz, input logic [7:0] exstrb, input logic [63:0] exwd,
                                input logic [63:0] exrd, input logic experr, input bit chain);
        vec_t v;
        v.wen = wen; v.addr = addr; v.size = size; v.wdata = wdata; v.slv_rdata = srd; v.resp = resp;
        v.ar_dly = ard; v.r_dly = rd; v.aw_dly = awd; v.w_dly = wd; v.b_dly = bd;
        v.exp_axsize = exsz; v.exp_strb = exstrb; v.exp_wdata = exwd; v.exp_rdata = exrd;
        v.exp_err = experr; v.chain = chain;
        return v;
    endfunction

    // Completion pulse must last one cycle; bus error only alongside completion.
    always @(negedge clk) begin
        if (prev_ready) check("ready_single_pulse", o_ram_ready, 1'b0);
        if (!o_ram_ready) check("bus_err_only_with_ready", o_bus_err, 1'b0);
        prev_ready = o_ram_ready;
    end

    task automatic drive_req(input int idx);
        sb_t e;
        e.wen   = vec[idx].wen;
        e.rdata = vec[idx].exp_rdata;
        e.err   = vec[idx].exp_err;
        if (vec[idx].wen)
            e.lat = 3 + ((vec[idx].aw_dly > vec[idx].w_dly) ? vec[idx].aw_dly : vec[idx].w_dly) + vec[idx].b_dly;
        else
            e.lat = 3 + vec[idx].ar_dly + vec[idx].r_dly;
        sb_q.push_back(e);
        i_ram_valid = 1'b1;
        i_ram_wen   = vec[idx].wen;
        i_ram_addr  = vec[idx].addr;
        i_ram_size  = vec[idx].size;
        i_ram_wdata = vec[idx].wdata;
    endtask

    // Plays the AXI slave for one transaction, then scores the completion.
    task automatic wait_txn(input int idx, input bit cin, output bit cout);
        vec_t v = vec[idx];
        sb_t  e;
        int   cyc = 0, arw = 0, rw = 0, aww = 0, ww = 0, bw = 0;
        int   ar_hs = 0, aw_hs = 0, w_hs = 0, aw_cyc = 0, w_cyc = 0, b_cyc = 0, r_cyc = 0;
        int   bad_b = 0, wrong_ch = 0;
        bit   done = 0;
        cout = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            i_axi_ar_ready = 1'b0; i_axi_r_valid = 1'b0; i_axi_r_resp = 2'b00;
            i_axi_r_data = 64'hDEAD_DEAD_DEAD_DEAD;
            i_axi_aw_ready = 1'b0; i_axi_w_ready = 1'b0; i_axi_b_valid = 1'b0; i_axi_b_resp = 2'b00;
            if (o_axi_b_ready) begin
                b_cyc++;
                if (aw_hs == 0 || w_hs == 0) bad_b++;
                if (bw == v.b_dly) begin i_axi_b_valid = 1'b1; i_axi_b_resp = v.resp; end
                else bw++;
            end
            if (o_axi_r_ready) begin
                r_cyc++;
                if (rw == v.r_dly) begin
                    i_axi_r_valid = 1'b1; i_axi_r_resp = v.resp; i_axi_r_data = v.slv_rdata;
                end else rw++;
            end
            if (o_axi_ar_valid) begin
                if (v.wen) wrong_ch++;
                if (arw == v.ar_dly) begin
                    i_axi_ar_ready = 1'b1; ar_hs++; ar_hs_total++;
                    check($sformatf("v%0d_araddr", idx), o_axi_ar_addr, v.addr[31:0]);
                    check($sformatf("v%0d_arsize", idx), o_axi_ar_size, v.exp_axsize);
                    check($sformatf("v%0d_arlen_burst_id", idx),
                          {o_axi_ar_len, o_axi_ar_burst, o_axi_ar_id}, {8'd0, 2'b01, 4'd0});
                end else arw++;
            end
            if (o_axi_aw_valid) begin
                if (!v.wen) wrong_ch++;
                aw_cyc++;
                if (aww == v.aw_dly) begin
                    i_axi_aw_ready = 1'b1; aw_hs++;
                    check($sformatf("v%0d_awaddr", idx), o_axi_aw_addr, v.addr[31:0]);
                    check($sformatf("v%0d_awsize", idx), o_axi_aw_size, v.exp_axsize);
                    check($sformatf("v%0d_awlen_burst_id", idx),
                          {o_axi_aw_len, o_axi_aw_burst, o_axi_aw_id}, {8'd0, 2'b01, 4'd0});
                end else aww++;
            end
            if (o_axi_w_valid) begin
                if (!v.wen) wrong_ch++;
                w_cyc++;
                if (ww == v.w_dly) begin
                    i_axi_w_ready = 1'b1; w_hs++;
                    check($sformatf("v%0d_wdata", idx), o_axi_w_data, v.exp_wdata);
                    check($sformatf("v%0d_wstrb", idx), o_axi_w_strb, v.exp_strb);
                    check($sformatf("v%0d_wlast", idx), o_axi_w_last, 1'b1);
                end else ww++;
            end
            if (o_ram_ready) begin
                done = 1;
                if (sb_q.size() == 0) begin
                    check($sformatf("v%0d_sb_nonempty", idx), 0, 1);
                end else begin
                    e = sb_q.pop_front();
                    if (!e.wen) begin
                        check($sformatf("v%0d_rdata", idx), o_ram_rdata, e.rdata);
                        last_rdata = e.rdata;
                    end
                    check($sformatf("v%0d_bus_err", idx), o_bus_err, e.err);
                    check($sformatf("v%0d_latency", idx), cyc, e.lat + (cin ? 1 : 0));
                end
                if (v.chain && idx + 1 < NVEC) begin
                    drive_req(idx + 1);
                    cout = 1;
                end else begin
                    i_ram_valid = 1'b0;
                end
            end
        end
        i_axi_ar_ready = 1'b0; i_axi_aw_ready = 1'b0; i_axi_w_ready = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL v%0d_timeout actual=no_ready required=ready_within_100_cycles", idx);
            i_ram_valid = 1'b0;
        end
        check($sformatf("v%0d_ar_handshakes", idx), ar_hs, v.wen ? 0 : 1);
        check($sformatf("v%0d_aw_handshakes", idx), aw_hs, v.wen ? 1 : 0);
        check($sformatf("v%0d_w_handshakes", idx), w_hs, v.wen ? 1 : 0);
        check($sformatf("v%0d_wrong_channel", idx), wrong_ch, 0);
        if (v.wen) begin
            check($sformatf("v%0d_awvalid_cycles", idx), aw_cyc, v.aw_dly + 1);
            check($sformatf("v%0d_wvalid_cycles", idx), w_cyc, v.w_dly + 1);
            check($sformatf("v%0d_bready_cycles", idx), b_cyc, v.b_dly + 1);
            check($sformatf("v%0d_bready_early", idx), bad_b, 0);
        end else begin
            check($sformatf("v%0d_rready_cycles", idx), r_cyc, v.r_dly + 1);
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, "_valids"}, {o_axi_ar_valid, o_axi_aw_valid, o_axi_w_valid,
                                  o_axi_r_ready, o_axi_b_ready, o_ram_ready, o_bus_err}, 7'd0);
        check({name, "_rdata"}, o_ram_rdata, 64'd0);
    endtask

    initial begin
        bit cin, cout, got_r;
        int n_reads = 0;
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit cin, cout, got_r;
        int n_reads;
        rst = 1'b1;
        i_ram_addr = '0; i_ram_wen = 1'b0; i_ram_valid = 1'b0; i_ram_wdata = '0; i_ram_size = '0;
        i_axi_aw_ready = 1'b0; i_axi_w_ready = 1'b0; i_axi_b_valid = 1'b0; i_axi_b_id = '0;
        i_axi_b_resp = '0; i_axi_ar_ready = 1'b0; i_axi_r_valid = 1'b0; i_axi_r_id = '0;
        i_axi_r_resp = '0; i_axi_r_data = '0; i_axi_r_last = 1'b1;

        //              wen addr                    sz wdata                  slave rdata            resp   ar r aw w b  axsz strb   exp wdata              exp rdata              err chain
        vec[0]  = mk(0, 64'h0000_0000_8000_0000, 3, 64'h0,                 64'h1122334455667788, 2'b00, 0, 3, 0, 0, 0, 3, 8'h00, 64'h0,                 64'h1122334455667788, 0, 0);
        vec[1]  = mk(0, 64'h0000_0000_8000_0004, 2, 64'h0,                 64'hDEADBEEF00000000, 2'b00, 1, 0, 0, 0, 0, 2, 8'h00, 64'h0,                 64'h00000000DEADBEEF, 0, 0);
        vec[2]  = mk(1, 64'h0000_0000_8000_0003, 0, 64'hAB,                64'h0,                2'b00, 0, 0, 0, 0, 2, 0, 8'h08, 64'h00000000AB000000, 64'h0,                 0, 0);
        vec[3]  = mk(1, 64'h0000_0000_8000_0010, 3, 64'h0102030405060708, 64'h0,                2'b00, 0, 0, 2, 0, 0, 3, 8'hFF, 64'h0102030405060708, 64'h0,                 0, 0);
        vec[4]  = mk(0, 64'h0000_0000_8000_0006, 1, 64'h0,                 64'hCAFE000000000000, 2'b10, 0, 1, 0, 0, 0, 1, 8'h00, 64'h0,                 64'h000000000000CAFE, 1, 0);
        vec[5]  = mk(1, 64'h0000_0000_8000_0005, 1, 64'hFFFFFFFFFFFF1234, 64'h0,                2'b11, 0, 0, 1, 3, 0, 1, 8'h60, 64'hFF12340000000000, 64'h0,                 1, 0);
        vec[6]  = mk(1, 64'h0000_0000_8000_0008, 7, 64'h55,                64'h0,                2'b00, 0, 0, 0, 0, 0, 3, 8'hFF, 64'h55,                64'h0,                 0, 0);
        vec[7]  = mk(1, 64'h0000_0000_8000_0006, 2, 64'hA1B2C3D4,          64'h0,                2'b00, 0, 0, 0, 0, 1, 2, 8'hC0, 64'hC3D4000000000000, 64'h0,                 0, 0);
        vec[8]  = mk(0, 64'h0000_0000_8000_0007, 0, 64'h0,                 64'h9A00000000000000, 2'b00, 2, 0, 0, 0, 0, 0, 8'h00, 64'h0,                 64'h000000000000009A, 0, 0);
        vec[9]  = mk(0, 64'h0000_0001_8000_0001, 0, 64'h0,                 64'h0000000000007700, 2'b00, 0, 0, 0, 0, 0, 0, 8'h00, 64'h0,                 64'h0000000000000077, 0, 0);
        vec[10] = mk(0, 64'h0000_0000_8000_0020, 3, 64'h0,                 64'h1111,             2'b00, 0, 0, 0, 0, 0, 3, 8'h00, 64'h0,                 64'h1111,              0, 1);
        vec[11] = mk(0, 64'h0000_0000_8000_0028, 3, 64'h0,                 64'h2222,             2'b00, 0, 0, 0, 0, 0, 3, 8'h00, 64'h0,                 64'h2222,              0, 0);

        n_reads = 0;
        for (int i = 0; i < NVEC; i++) if (!vec[i].wen) n_reads++;

        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("idle_after_reset");

        drive_req(0);
        cin = 0;
        for (int i = 0; i < NVEC; i++) begin
            wait_txn(i, cin, cout);
            cin = cout;
            if (!cout) begin
                @(negedge clk);
                check($sformatf("v%0d_rdata_held", i), o_ram_rdata, last_rdata);
                if (i + 1 < NVEC) drive_req(i + 1);
            end
        end
        check("ar_handshakes_total", ar_hs_total, n_reads);

        // Reset while waiting for read data.
        @(negedge clk);
        i_ram_valid = 1'b1; i_ram_wen = 1'b0; i_ram_addr = 64'h8000_0040; i_ram_size = 3'd3;
        got_r = 0;
        for (int k = 0; k < 10 && !got_r; k++) begin
            @(negedge clk);
            i_axi_ar_ready = o_axi_ar_valid;
            if (o_axi_r_ready) begin
                got_r = 1; rst = 1'b1; i_ram_valid = 1'b0; i_axi_ar_ready = 1'b0;
            end
        end
        check("rst_reached_r_state", got_r, 1'b1);
        @(negedge clk);
        check_quiet("mid_txn_reset");
        rst = 1'b0;
        last_rdata = '0;
        @(negedge clk);
        check_quiet("idle_after_mid_reset");
        drive_req(0);
        wait_txn(0, 1'b0, cout);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
